bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 138 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble).
// Define BCD_BLANK_EN to enable leading-zero blank flags.
module bin_to_bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [3:0]  bcd_thou,
  output logic [3:0]  bcd_hund,
  output logic [3:0]  bcd_tens,
  output logic [3:0]  bcd_ones,
  output logic        overflow,
  output logic [3:0]  blank
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] scr_q, scr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        load;
  logic [15:0] adj;
  logic [29:0] sh;
  logic [15:0] dig_nx;

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < 4; i++) begin
      if (scr_q[4*i+:4] >= 4'd5) begin
        adj[4*i+:4] = scr_q[4*i+:4] + 4'd3;
      end
    end
    sh = {adj, bin_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          scr_d   = 16'd0;
          cnt_d   = 4'd0;
          ovf_d   = (bin_in > 14'd9999);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, bin_d} = sh;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          state_d = DONE;
        end
      end
      DONE: begin
        load    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Out-of-range inputs saturate to 9999.
  assign dig_nx = ovf_q ? 16'h9999 : scr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_thou <= 4'd0;
      bcd_hund <= 4'd0;
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
    end else begin
      busy <= (state_d != IDLE);
      done <= load;
      if (load) begin
        overflow <= ovf_q;
        bcd_thou <= dig_nx[15:12];
        bcd_hund <= dig_nx[11:8];
        bcd_tens <= dig_nx[7:4];
        bcd_ones <= dig_nx[3:0];
      end
    end
  end

`ifdef BCD_BLANK_EN
  logic [3:0] blank_nx;

  always_comb begin
    blank_nx    = 4'b0000;
    blank_nx[3] = (dig_nx[15:12] == 4'd0);
    blank_nx[2] = blank_nx[3] && (dig_nx[11:8] == 4'd0);
    blank_nx[1] = blank_nx[2] && (dig_nx[7:4] == 4'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank <= 4'b1110;
    end else if (load) begin
      blank <= blank_nx;
    end
  end
`else
  assign blank = 4'b0000;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and swept checks for bin_to_bcd_seq.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [3:0]  bcd_thou;
  logic [3:0]  bcd_hund;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_ones;
  logic        overflow;
  logic [3:0]  blank;

`ifdef BCD_BLANK_EN
  localparam logic [3:0] BM = 4'b1111;
`else
  localparam logic [3:0] BM = 4'b0000;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  bin_to_bcd_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_thou (bcd_thou),
    .bcd_hund (bcd_hund),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .overflow (overflow),
    .blank    (blank)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] res();
    return {bcd_thou, bcd_hund, bcd_tens, bcd_ones, overflow, blank};
  endfunction

  function automatic logic [20:0] model(input int v);
    logic [3:0] t, h, te, o, b;
    logic       ov;
    if (v > 9999) begin
      t = 9; h = 9; te = 9; o = 9; ov = 1'b1;
    end else begin
      t  = 4'(v / 1000);
      h  = 4'((v / 100) % 10);
      te = 4'((v / 10) % 10);
      o  = 4'(v % 10);
      ov = 1'b0;
    end
    b[3] = (t == 0);
    b[2] = b[3] && (h == 0);
    b[1] = b[2] && (te == 0);
    b[0] = 1'b0;
    return {t, h, te, o, ov, b & BM};
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic convert(input int v, output int lat, output logic b1);
    start  = 1'b1;
    bin_in = 14'(v);
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = ~14'(v);
    lat    = 0;
    b1     = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) b1 = busy;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  logic [20:0] dv_exp [6];
  int          dv_in  [6];

  initial begin
    int   lat, nd, dl, v;
    logic b1;

    rst = 1'b0; start = 1'b0; bin_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_done", 32'(done), 32'(1'b0));
    chk("rst_res", 32'(res()), 32'({16'h0000, 1'b0, 4'b1110 & BM}));
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'(1'b0));

    convert(1234, lat, b1);
    chk("1234_lat", 32'(lat), 32'd16);
    chk("1234_busy1", 32'(b1), 32'(1'b1));
    chk("1234_busy_done", 32'(busy), 32'(1'b0));
    chk("1234_res", 32'(res()), 32'({16'h1234, 1'b0, 4'b0000}));
    @(negedge clk);
    chk("1234_pulse", 32'(done), 32'(1'b0));
    chk("1234_hold", 32'(res()), 32'({16'h1234, 1'b0, 4'b0000}));

    dv_in[0] = 9999;  dv_exp[0] = {16'h9999, 1'b0, 4'b0000};
    dv_in[1] = 10000; dv_exp[1] = {16'h9999, 1'b1, 4'b0000};
    dv_in[2] = 16383; dv_exp[2] = {16'h9999, 1'b1, 4'b0000};
    dv_in[3] = 7;     dv_exp[3] = {16'h0007, 1'b0, 4'b1110 & BM};
    dv_in[4] = 0;     dv_exp[4] = {16'h0000, 1'b0, 4'b1110 & BM};
    dv_in[5] = 305;   dv_exp[5] = {16'h0305, 1'b0, 4'b1000 & BM};
    for (int i = 0; i < 6; i++) begin
      convert(dv_in[i], lat, b1);
      chk($sformatf("dv%0d_lat", dv_in[i]), 32'(lat), 32'd16);
      chk($sformatf("dv%0d_res", dv_in[i]), 32'(res()), 32'(dv_exp[i]));
    end

    start = 1'b1; bin_in = 14'd4321;
    @(posedge clk);
    #1;
    start = 1'b0; bin_in = 14'd55;
    nd = 0; dl = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 10);
      if (done) begin
        nd++;
        dl = c;
      end
    end
    start = 1'b0;
    chk("ign_ndone", 32'(nd), 32'd1);
    chk("ign_lat", 32'(dl), 32'd16);
    chk("ign_res", 32'(res()), 32'({16'h4321, 1'b0, 4'b0000}));

    start = 1'b1; bin_in = 14'd5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_res", 32'(res()), 32'({16'h0000, 1'b0, 4'b1110 & BM}));
    chk("abort_busy", 32'(busy), 32'(1'b0));
    chk("abort_done", 32'(done), 32'(1'b0));
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_nodone", 32'(nd), 32'd0);
    rst = 1'b1;
    convert(42, lat, b1);
    chk("42_lat", 32'(lat), 32'd16);
    chk("42_res", 32'(res()), 32'({16'h0042, 1'b0, 4'b1100 & BM}));

    for (int i = 9990; i <= 10010; i++) begin
      convert(i, lat, b1);
      chk($sformatf("edge%0d", i), 32'({lat == 16, res()}),
          32'({1'b1, model(i)}));
    end

    for (int i = 0; i <= 2341; i++) begin
      v = (i == 2341) ? 16383 : i * 7;
      convert(v, lat, b1);
      chk($sformatf("sweep%0d", v), 32'({lat == 16, res()}),
          32'({1'b1, model(v)}));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
